// File: rtl/times_divide_if.sv
// ============================================================================
// times_divide_if : start/busy/done handshake and operand/result bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface times_divide_if #(
  parameter int WIDTH_N = 6,
  parameter int WIDTH_D = 3
);
  logic               start;
  logic [WIDTH_N-1:0] dividend;
  logic [WIDTH_D-1:0] divisor;
  logic [WIDTH_N-1:0] quotient;
  logic [WIDTH_D-1:0] remainder;
  logic               busy;
  logic               done;
  logic               div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/times_divide.sv
// ============================================================================
// times_divide : restoring divider, one quotient bit per clock, MSB first
// Revision 1.0
// ============================================================================
`default_nettype none

module times_divide #(
  parameter int WIDTH_N = 6,
  parameter int WIDTH_D = 3
) (
  input  wire logic    clk,
  input  wire logic    rst,
  times_divide_if.slave bus
);

  localparam int                 CNT_W    = $clog2(WIDTH_N);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(WIDTH_N - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH_N-1:0] r_dvd;
  logic [WIDTH_D-1:0] r_dsr;
  logic [WIDTH_D-1:0] r_prem;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH_N-1:0] r_qacc;
  logic [WIDTH_N-1:0] r_quotient;
  logic [WIDTH_D-1:0] r_remainder;
  logic               r_busy;
  logic               r_done;
  logic               r_div_by_zero;

  logic [WIDTH_D:0]   w_shifted;
  logic               w_ge;
  logic [WIDTH_D-1:0] w_rem_next;
  logic [WIDTH_N-1:0] w_quot_next;

  // The stored remainder is always below the divisor, so when the shifted
  // value is >= divisor the difference fits in WIDTH_D bits.
  always_comb begin
    w_shifted   = {r_prem, r_dvd[WIDTH_N-1]};
    w_ge        = (w_shifted >= {1'b0, r_dsr});
    w_rem_next  = w_ge ? (w_shifted[WIDTH_D-1:0] - r_dsr) : w_shifted[WIDTH_D-1:0];
    w_quot_next = {r_qacc[WIDTH_N-2:0], w_ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_dvd         <= '0;
      r_dsr         <= '0;
      r_prem        <= '0;
      r_cnt         <= '0;
      r_qacc        <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              r_quotient    <= '1;
              r_remainder   <= '0;
              r_div_by_zero <= 1'b1;
              r_done        <= 1'b1;
              r_state       <= S_DONE;
            end else begin
              r_dvd   <= bus.dividend;
              r_dsr   <= bus.divisor;
              r_prem  <= '0;
              r_qacc  <= '0;
              r_cnt   <= CNT_LOAD;
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_prem <= w_rem_next;
          r_dvd  <= {r_dvd[WIDTH_N-2:0], 1'b0};
          r_qacc <= w_quot_next;
          if (r_cnt == '0) begin
            r_quotient    <= w_quot_next;
            r_remainder   <= w_rem_next;
            r_div_by_zero <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_div_by_zero;

endmodule

`default_nettype wire

// File: tb/tb_times_divide.sv
// ============================================================================
// tb_times_divide : vector table, times-table round trip, random and corner runs
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_times_divide;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  times_divide_if #(.WIDTH_N(6), .WIDTH_D(3)) bus ();

  times_divide #(.WIDTH_N(6), .WIDTH_D(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int z;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division, all-ones quotient on zero divisor
  function automatic void model(input int a, input int b, output int q, output int r, output int z);
    if (b == 0) begin
      q = 63; r = 0; z = 1;
    end else begin
      q = a / b; r = a % b; z = 0;
    end
  endfunction

  // Issue one start and watch 16 cycles; inj>0 re-pulses start with 9/2 at that cycle
  task automatic do_div(input int a, input int b, input int inj,
                        output int q, output int r, output int z,
                        output int lat, output int nbusy, output int ndone, output int both);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 6'(a);
    bus.divisor  = 3'(b);
    q = -1; r = -1; z = -1; lat = -1; nbusy = 0; ndone = 0; both = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.busy && bus.done) both++;
      if (bus.done) begin
        ndone++;
        if (lat < 0) begin
          lat = i;
          q = int'(bus.quotient);
          r = int'(bus.remainder);
          z = int'(bus.div_by_zero);
        end
      end
      if (i == 1) bus.start = 1'b0;
      if (i == inj) begin
        bus.start = 1'b1; bus.dividend = 6'd9; bus.divisor = 3'd2;
      end
      if (i == inj + 1) bus.start = 1'b0;
    end
  endtask

  task automatic run_and_check(input string tag, input int a, input int b, input int inj, input bit timing);
    int q, r, z, lat, nb, nd, both, eq, er, ez;
    model(a, b, eq, er, ez);
    do_div(a, b, inj, q, r, z, lat, nb, nd, both);
    chk({tag, " quotient"}, q, eq);
    chk({tag, " remainder"}, r, er);
    chk({tag, " div_by_zero"}, z, ez);
    if (timing) begin
      chk({tag, " done_cycle"}, lat, (ez != 0) ? 1 : 7);
      chk({tag, " busy_cycles"}, nb, (ez != 0) ? 0 : 6);
      chk({tag, " done_pulses"}, nd, 1);
      chk({tag, " busy_and_done"}, both, 0);
    end
  endtask

  vec_t tbl [7];

  initial begin
    int zero_bad;
    errors = 0;
    checks = 0;
    tbl[0] = '{a: 42, b: 6, q: 7,  r: 0, z: 0};
    tbl[1] = '{a: 50, b: 4, q: 12, r: 2, z: 0};
    tbl[2] = '{a: 63, b: 1, q: 63, r: 0, z: 0};
    tbl[3] = '{a: 0,  b: 5, q: 0,  r: 0, z: 0};
    tbl[4] = '{a: 5,  b: 7, q: 0,  r: 5, z: 0};
    tbl[5] = '{a: 17, b: 0, q: 63, r: 0, z: 1};
    tbl[6] = '{a: 20, b: 3, q: 6,  r: 2, z: 0};

    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      zero_bad = int'(bus.quotient) + int'(bus.remainder) + int'(bus.busy)
               + int'(bus.done) + int'(bus.div_by_zero);
      chk("idle_outputs_zero", zero_bad, 0);
    end

    for (int i = 0; i < 7; i++) begin
      int q, r, z, lat, nb, nd, both;
      do_div(tbl[i].a, tbl[i].b, 0, q, r, z, lat, nb, nd, both);
      chk($sformatf("vec%0d quotient", i), q, tbl[i].q);
      chk($sformatf("vec%0d remainder", i), r, tbl[i].r);
      chk($sformatf("vec%0d div_by_zero", i), z, tbl[i].z);
      chk($sformatf("vec%0d done_cycle", i), lat, (tbl[i].z != 0) ? 1 : 7);
      chk($sformatf("vec%0d busy_cycles", i), nb, (tbl[i].z != 0) ? 0 : 6);
      chk($sformatf("vec%0d done_pulses", i), nd, 1);
    end

    for (int a = 0; a < 8; a++)
      for (int b = 1; b < 8; b++)
        for (int r = 0; r < b; r++)
          run_and_check($sformatf("tt %0d*%0d+%0d", a, b, r), a * b + r, b, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      int a, b;
      a = int'($urandom_range(0, 63));
      b = int'($urandom_range(0, 7));
      run_and_check($sformatf("rnd %0d/%0d", a, b), a, b, 0, 1'b1);
    end

    // Second request and operand changes land in the 3rd CALC cycle
    run_and_check("busy_start 45/5", 45, 5, 3, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("busy_start no_restart", int'(bus.busy) + int'(bus.done), 0);
    end

    // Reset asserted off-edge during the 4th CALC cycle
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 6'd60; bus.divisor = 3'd7;
    @(posedge clk);
    @(negedge clk) bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid quotient", int'(bus.quotient), 0);
    chk("rst_mid remainder", int'(bus.remainder), 0);
    chk("rst_mid busy", int'(bus.busy), 0);
    chk("rst_mid done", int'(bus.done), 0);
    chk("rst_mid div_by_zero", int'(bus.div_by_zero), 0);
    @(negedge clk) rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        seen += int'(bus.done) + int'(bus.busy);
      end
      chk("rst_mid no_done", seen, 0);
    end
    run_and_check("after_rst 60/7", 60, 7, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
